// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment bus decoder and the display driver:
// FSM encoding, digit count and the active-high hex glyph set {g,f,e,d,c,b,a}.
package ssd_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SETTLE = 2'd1;
    localparam state_t ST_HELD   = 2'd2;

    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h7C;
    localparam logic [6:0] GLYPH_C = 7'h39;
    localparam logic [6:0] GLYPH_D = 7'h5E;
    localparam logic [6:0] GLYPH_E = 7'h79;
    localparam logic [6:0] GLYPH_F = 7'h71;

    // Only meaningful for a one-hot select; callers check that first.
    function automatic logic [1:0] onehot_index(input logic [NUM_DIGITS-1:0] sel);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ssd_glyph_decode.sv
// Combinational map from an active-high segment pattern to its hex nibble;
// legal drops for anything outside the sixteen standard glyphs.
module ssd_glyph_decode
    import ssd_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       legal
);

    always_comb begin
        nibble = 4'h0;
        legal  = 1'b1;
        case (seg)
            GLYPH_0: nibble = 4'h0;
            GLYPH_1: nibble = 4'h1;
            GLYPH_2: nibble = 4'h2;
            GLYPH_3: nibble = 4'h3;
            GLYPH_4: nibble = 4'h4;
            GLYPH_5: nibble = 4'h5;
            GLYPH_6: nibble = 4'h6;
            GLYPH_7: nibble = 4'h7;
            GLYPH_8: nibble = 4'h8;
            GLYPH_9: nibble = 4'h9;
            GLYPH_A: nibble = 4'hA;
            GLYPH_B: nibble = 4'hB;
            GLYPH_C: nibble = 4'hC;
            GLYPH_D: nibble = 4'hD;
            GLYPH_E: nibble = 4'hE;
            GLYPH_F: nibble = 4'hF;
            default: legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/ssd_decode.sv
// Snoops a multiplexed four-digit seven-segment bus and rebuilds the displayed
// 16-bit hex value once every digit has been seen stable and legal.
module ssd_decode
    import ssd_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_DIGITS-1:0] anode,
    input  logic [6:0]            seg,
    output logic [15:0]           value,
    output logic                  valid,
    output logic                  frame_done,
    output logic                  digit_err
);

    localparam logic [NUM_DIGITS-1:0] ANODE_OFF  = SEG_ACTIVE_LOW ? '1 : '0;
    localparam logic [6:0]            SEG_OFF    = SEG_ACTIVE_LOW ? '1 : '0;
    localparam logic [7:0]            STABLE_CNT = 8'(STABLE_CYCLES);

    logic [NUM_DIGITS-1:0] anode_meta, anode_sync, anode_hi;
    logic [6:0]            seg_meta, seg_sync, seg_hi;

    state_t                     state;
    logic [7:0]                 cnt;
    logic [NUM_DIGITS-1:0]      rec_anode;
    logic [6:0]                 rec_seg;
    logic [1:0]                 rec_idx;
    logic [NUM_DIGITS-1:0]      mask, new_mask;
    logic [NUM_DIGITS-1:0][3:0] slots, next_slots;

    logic       one_hot, same, capture;
    logic [3:0] nibble;
    logic       legal;

    // Bus lines are asynchronous to clk; idle level keeps the FSM in IDLE after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode_meta <= ANODE_OFF;
            anode_sync <= ANODE_OFF;
            seg_meta   <= SEG_OFF;
            seg_sync   <= SEG_OFF;
        end else begin
            anode_meta <= anode;
            anode_sync <= anode_meta;
            seg_meta   <= seg;
            seg_sync   <= seg_meta;
        end
    end

    assign anode_hi = SEG_ACTIVE_LOW ? ~anode_sync : anode_sync;
    assign seg_hi   = SEG_ACTIVE_LOW ? ~seg_sync   : seg_sync;

    ssd_glyph_decode u_glyph (
        .seg    (rec_seg),
        .nibble (nibble),
        .legal  (legal)
    );

    assign one_hot  = $onehot(anode_hi);
    assign same     = (anode_hi == rec_anode) && (seg_hi == rec_seg);
    assign capture  = (state == ST_SETTLE) && same && (cnt >= STABLE_CNT);
    assign new_mask = mask | (NUM_DIGITS'(1) << rec_idx);

    always_comb begin
        next_slots          = slots;
        next_slots[rec_idx] = nibble;
    end

    // Any change of anode or segments restarts settling from the new values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            rec_anode  <= '0;
            rec_seg    <= '0;
            rec_idx    <= '0;
            mask       <= '0;
            slots      <= '0;
            value      <= '0;
            valid      <= 1'b0;
            frame_done <= 1'b0;
            digit_err  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            digit_err  <= 1'b0;
            if (state == ST_IDLE || !same) begin
                if (one_hot) begin
                    state     <= ST_SETTLE;
                    cnt       <= 8'd1;
                    rec_anode <= anode_hi;
                    rec_seg   <= seg_hi;
                    rec_idx   <= onehot_index(anode_hi);
                end else begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            end else if (capture) begin
                state <= ST_HELD;
                if (legal) begin
                    slots <= next_slots;
                    if (new_mask == '1) begin
                        value      <= next_slots;
                        valid      <= 1'b1;
                        frame_done <= 1'b1;
                        mask       <= '0;
                    end else begin
                        mask <= new_mask;
                    end
                end else begin
                    digit_err <= 1'b1;
                    mask      <= '0;
                end
            end else if (state == ST_SETTLE) begin
                cnt <= (cnt == 8'hFF) ? cnt : cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ssd_decode.sv
// Directed bench for ssd_decode with default parameters (active-low bus,
// four stable cycles); expected values are hand-computed glyph decodes.
module tb_ssd_decode;

    localparam logic [3:0] AN0 = 4'b1110;
    localparam logic [3:0] AN1 = 4'b1101;
    localparam logic [3:0] AN2 = 4'b1011;
    localparam logic [3:0] AN3 = 4'b0111;
    localparam logic [3:0] OFF = 4'b1111;
    localparam logic [3:0] AN01 = 4'b1100;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SF = 7'b0001110;
    localparam logic [6:0] SX = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  anode = OFF;
    logic [6:0]  seg = SX;
    logic [15:0] value;
    logic        valid, frame_done, digit_err;

    int checks = 0;
    int errors = 0;
    int frame_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        string       name;
        logic [3:0]  an;
        logic [6:0]  sg;
        int          cycles;
        logic [15:0] exp_value;
        logic        exp_valid;
        int          exp_frames;
        int          exp_errs;
    } vec_t;

    vec_t vecs[$];

    ssd_decode #(.STABLE_CYCLES(4), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .anode      (anode),
        .seg        (seg),
        .value      (value),
        .valid      (valid),
        .frame_done (frame_done),
        .digit_err  (digit_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) frame_cnt++;
        if (digit_err === 1'b1) err_cnt++;
    end

    task automatic applyStimulus(input logic [3:0] a, input logic [6:0] s, input int cycles);
        anode = a;
        seg   = s;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic addVec(input string n, input logic [3:0] a, input logic [6:0] s, input int cyc,
                          input logic [15:0] v, input logic vl, input int f, input int e);
        vec_t t;
        t.name = n; t.an = a; t.sg = s; t.cycles = cyc;
        t.exp_value = v; t.exp_valid = vl; t.exp_frames = f; t.exp_errs = e;
        vecs.push_back(t);
    endtask

    initial begin
        int base_f;
        int base_e;
        int first_n;
        int high_n;

        addVec("idle",        OFF,  SX, 4, 16'h0000, 1'b0, 0, 0);
        addVec("f1_d0",       AN0,  S0, 8, 16'h0000, 1'b0, 0, 0);
        addVec("f1_d1",       AN1,  S1, 8, 16'h0000, 1'b0, 0, 0);
        addVec("f1_d2",       AN2,  S2, 8, 16'h0000, 1'b0, 0, 0);
        addVec("f1_d3",       AN3,  S3, 8, 16'h3210, 1'b1, 1, 0);
        addVec("f2_d0",       AN0,  SA, 8, 16'h3210, 1'b1, 1, 0);
        addVec("f2_d1",       AN1,  SF, 8, 16'h3210, 1'b1, 1, 0);
        addVec("f2_d2",       AN2,  SA, 8, 16'h3210, 1'b1, 1, 0);
        addVec("f2_d3",       AN3,  SF, 8, 16'hFAFA, 1'b1, 2, 0);
        addVec("f3_d0",       AN0,  S0, 8, 16'hFAFA, 1'b1, 2, 0);
        addVec("f3_d2",       AN2,  S2, 8, 16'hFAFA, 1'b1, 2, 0);
        addVec("f3_d3",       AN3,  S3, 8, 16'hFAFA, 1'b1, 2, 0);
        addVec("illegal_d1",  AN1,  SX, 8, 16'hFAFA, 1'b1, 2, 1);
        addVec("after_err",   AN1,  S1, 8, 16'hFAFA, 1'b1, 2, 1);
        addVec("two_anodes",  AN01, S0, 8, 16'hFAFA, 1'b1, 2, 1);
        addVec("f4_d0",       AN0,  S0, 8, 16'hFAFA, 1'b1, 2, 1);
        addVec("f4_d0_over",  AN0,  SF, 8, 16'hFAFA, 1'b1, 2, 1);
        addVec("f4_d2",       AN2,  S2, 8, 16'hFAFA, 1'b1, 2, 1);
        addVec("f4_d3",       AN3,  S3, 8, 16'h321F, 1'b1, 3, 1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_value", 32'(value), 32'h0);
        checkOutput("rst_valid", 32'(valid), 32'h0);
        checkOutput("rst_frame_done", 32'(frame_done), 32'h0);
        checkOutput("rst_digit_err", 32'(digit_err), 32'h0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].an, vecs[i].sg, vecs[i].cycles);
            checkOutput($sformatf("%s.value", vecs[i].name), 32'(value), 32'(vecs[i].exp_value));
            checkOutput($sformatf("%s.valid", vecs[i].name), 32'(valid), 32'(vecs[i].exp_valid));
            checkOutput($sformatf("%s.frames", vecs[i].name), 32'(frame_cnt), 32'(vecs[i].exp_frames));
            checkOutput($sformatf("%s.errs", vecs[i].name), 32'(err_cnt), 32'(vecs[i].exp_errs));
        end

        // Glitch: digit 2 changes after three cycles, capture must wait for the new pattern.
        applyStimulus(AN0, SA, 8);
        applyStimulus(AN1, SA, 8);
        applyStimulus(AN3, SA, 8);
        applyStimulus(AN2, S2, 3);
        applyStimulus(AN2, SF, 5);
        checkOutput("glitch_early_frames", 32'(frame_cnt), 32'd3);
        checkOutput("glitch_early_value", 32'(value), 32'h321F);
        applyStimulus(AN2, SF, 3);
        checkOutput("glitch_frames", 32'(frame_cnt), 32'd4);
        checkOutput("glitch_value", 32'(value), 32'hAFAA);

        // Latency: frame_done follows the fourth digit's first sampling edge by 2+4 edges.
        applyStimulus(AN0, S0, 8);
        applyStimulus(AN1, S1, 8);
        applyStimulus(AN2, S2, 8);
        anode = AN3;
        seg = S3;
        first_n = -1;
        high_n = 0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (frame_done === 1'b1) begin
                high_n++;
                if (first_n < 0) first_n = n;
            end
        end
        checkOutput("latency_edge", 32'(first_n), 32'd6);
        checkOutput("latency_pulse_width", 32'(high_n), 32'd1);
        checkOutput("latency_value", 32'(value), 32'h3210);

        // Reset mid-frame discards partial captures.
        applyStimulus(AN0, SA, 8);
        applyStimulus(AN1, SA, 8);
        applyStimulus(AN2, S2, 4);
        rst_n = 1'b0;
        anode = OFF;
        seg = SX;
        #1;
        checkOutput("async_rst_value", 32'(value), 32'h0);
        checkOutput("async_rst_valid", 32'(valid), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("mid_rst_frame_done", 32'(frame_done), 32'h0);
        checkOutput("mid_rst_digit_err", 32'(digit_err), 32'h0);
        rst_n = 1'b1;
        base_f = frame_cnt;
        base_e = err_cnt;
        applyStimulus(OFF, SX, 6);
        checkOutput("release_no_frame", 32'(frame_cnt - base_f), 32'd0);
        checkOutput("release_no_err", 32'(err_cnt - base_e), 32'd0);
        applyStimulus(AN2, SF, 8);
        applyStimulus(AN3, SF, 8);
        checkOutput("partial_valid", 32'(valid), 32'h0);
        checkOutput("partial_value", 32'(value), 32'h0);
        checkOutput("partial_frames", 32'(frame_cnt - base_f), 32'd0);
        applyStimulus(AN0, S0, 8);
        applyStimulus(AN1, S1, 8);
        checkOutput("fresh_value", 32'(value), 32'hFF10);
        checkOutput("fresh_valid", 32'(valid), 32'h1);
        checkOutput("fresh_frames", 32'(frame_cnt - base_f), 32'd1);
        checkOutput("fresh_errs", 32'(err_cnt - base_e), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ssd_decode.md
SSD_DECODE -- requirements
Module: ssd_decode

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, meaning consecutive synchronized cycles a digit must hold before capture (legal range 1-255).
REQ-002 Parameter SEG_ACTIVE_LOW, default 1, meaning segment and anode lines are active-low when 1.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 anode  input  4  digit-select lines from the multiplexed display bus; bit i selects digit i.
REQ-006 seg  input  7  segment lines {g,f,e,d,c,b,a}.
REQ-007 value  output  16  last complete frame; digit i occupies value[4i+3:4i].
REQ-008 valid  output  1  high once a complete error-free frame has been latched.
REQ-009 frame_done  output  1  one-cycle pulse when value updates.
REQ-010 digit_err  output  1  one-cycle pulse when a stable digit pattern is not a legal hex glyph.

Function
REQ-011 anode and seg SHALL pass through a 2-flop synchronizer; all decisions use synchronized values (2-cycle input latency).
REQ-012 Polarity SHALL be normalized to active-high internally per SEG_ACTIVE_LOW.
REQ-013 FSM states: IDLE, SETTLE, HELD.
REQ-014 IDLE: no anode or more than one anode asserted; stability counter held at 0.
REQ-015 IDLE->SETTLE when exactly one anode is asserted; counter loads 1 and the selected digit index and seg pattern are recorded.
REQ-016 SETTLE: counter increments (saturating at 8-bit max) while anode and seg are unchanged; any change in either SHALL restart SETTLE with the new values (or go to IDLE if the anode is no longer one-hot).
REQ-017 SETTLE->HELD when counter reaches STABLE_CYCLES; in that cycle the pattern SHALL be decoded and stored in the digit slot, and the slot's seen-mask bit set.
REQ-018 Decode SHALL accept exactly the 16 standard hex glyphs (0-9, A, b, C, d, E, F); any other pattern SHALL pulse digit_err, SHALL not set the mask bit, and SHALL clear the whole seen-mask.
REQ-019 HELD: no further capture until anode or seg changes; then behave as REQ-016 transitions from SETTLE.
REQ-020 When the seen-mask becomes 4'b1111, in the same cycle value SHALL load all four slots, frame_done pulse, valid set, mask clear to 0.
REQ-021 Recapturing a digit already in the mask SHALL overwrite its slot; this does not complete a frame.
REQ-022 valid SHALL stay high until reset; digit_err does not clear valid or value.
REQ-023 Capture latency: frame_done asserts exactly 2 + STABLE_CYCLES cycles after the fourth digit's stable inputs reach the pins, minus 0 (counted from first edge sampling them).

Reset
REQ-024 On rst_n low: value=16'h0000, valid=0, frame_done=0, digit_err=0, FSM=IDLE, counter=0, mask=0, slots=0, synchronizer flops to inactive level.
REQ-025 Reset asserted mid-SETTLE or mid-frame SHALL discard all partial state; no pulse is emitted on reset release.

Structure
REQ-026 Shared package ssd_pkg SHALL hold the FSM state typedef, NUM_DIGITS=4, and the 16 glyph constants, shared with the display driver.
REQ-027 Glyph-to-nibble decode SHALL be a separate combinational sub-module ssd_glyph_decode (seg in, nibble + legal out).

Verification
REQ-028 Reset: drive rst_n low mid-frame -> all outputs 0, next frame needs four fresh captures.
REQ-029 Full frame, active-low, STABLE_CYCLES=4: digits 0..3 show 7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000 for 6 cycles each -> value=16'h3210, frame_done one pulse, valid=1.
REQ-030 Glitch: digit 2 seg changes after 3 stable cycles -> no capture until 4 new stable cycles; value unaffected.
REQ-031 Illegal glyph 7'b1111111 held on digit 1 -> digit_err one pulse, mask cleared, no frame_done.
REQ-032 Two anodes asserted (4'b1100 active-low: digits 0,1) -> IDLE, no capture, no pulses.
REQ-033 Second frame 7'b0001000 (A) and 7'b0001110 (F) repeated -> value=16'hFAFA, valid remains 1, frame_done pulses again.
